// File: rtl/comparator_selftest.sv
// comparator_selftest: steps every switch vector through a comparator and checks z against A > B
module comparator_selftest #(
  parameter int N = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           z,
  output logic [2*N-1:0] switch,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N:0]   err_count,
  output logic [2*N-1:0] first_fail,
  output logic           first_fail_valid
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       miss;
  logic [2*N:0] err_next;
  // mismatch of the current sample and the count it would produce
  always_comb begin
    miss     = z != (switch[2*N-1:N] > switch[N-1:0]);
    err_next = err_count + (2*N+1)'(miss);
  end
  // run sequencer: drive, settle, sample, advance; abort wins over a sample update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      switch           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == DRIVE || state == SAMPLE) && abort) begin
        state  <= IDLE;
        busy   <= 1'b0;
        switch <= '0;
        pass   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            state            <= DRIVE;
            busy             <= 1'b1;
            switch           <= '0;
            cnt              <= '0;
            err_count        <= '0;
            pass             <= 1'b0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
          end
          DRIVE: begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(SETTLE_CYCLES - 1)) state <= SAMPLE;
          end
          SAMPLE: begin
            err_count <= err_next;
            if (miss && !first_fail_valid) begin
              first_fail       <= switch;
              first_fail_valid <= 1'b1;
            end
            if (&switch) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= err_next == '0;
            end else begin
              switch <= switch + 1'b1;
              cnt    <= '0;
              state  <= DRIVE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
